// File: rtl/ysyx_23060240_sram_slave_if.sv
// ysyx_23060240_sram_slave_if: AXI4-Lite channel bundle between a bus master and the SRAM slave
interface ysyx_23060240_sram_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060240_sram_slave.sv
// ysyx_23060240_sram_slave: AXI4-Lite word SRAM responder, fixed LAT wait; SRAM_RAND_DELAY_EN adds 0..7 LFSR cycles
module ysyx_23060240_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT         = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    ysyx_23060240_sram_slave_if.slave sram
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP} state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_addr, r_wdata, r_rdata;
    logic [3:0]         r_wstrb;
    logic               r_aw_got, r_w_got;
    logic [4:0]         r_cnt;
    logic [1:0]         r_rresp, r_bresp;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        w_addr, w_data, w_off;
    logic [3:0]         w_strb;
    logic [4:0]         w_wait;
    logic [IDX_W-1:0]   w_idx;
    logic               w_hit, w_idle, w_coll, w_ar_take, w_aw_take, w_w_take, w_rd_load, w_wr_load;

    assign w_idle    = r_state == IDLE;
    assign w_coll    = r_state == WR_COLLECT;
    assign w_ar_take = w_idle & sram.arvalid;
    assign w_aw_take = sram.awvalid & (w_idle & ~sram.arvalid | w_coll & ~r_aw_got);
    assign w_w_take  = sram.wvalid & (w_idle & ~sram.arvalid | w_coll & ~r_w_got);

    // Bypass freshly captured request fields so a zero-wait access uses them in the capture cycle
    assign w_addr = w_ar_take ? sram.araddr : w_aw_take ? sram.awaddr : r_addr;
    assign w_data = w_w_take ? sram.wdata : r_wdata;
    assign w_strb = w_w_take ? sram.wstrb : r_wstrb;

    // Unsigned wrap makes addresses below BASE_ADDR land outside SPAN as well
    assign w_off = w_addr - BASE_ADDR;
    assign w_hit = w_off < SPAN;
    assign w_idx = w_off[IDX_W+1:2];

    assign sram.arready = rst_n & w_idle;
    assign sram.awready = rst_n & (w_idle | w_coll & ~r_aw_got);
    assign sram.wready  = rst_n & (w_idle | w_coll & ~r_w_got);
    assign sram.rvalid  = r_state == RD_RESP;
    assign sram.bvalid  = r_state == WR_RESP;
    assign sram.rdata   = r_rdata;
    assign sram.rresp   = r_rresp;
    assign sram.bresp   = r_bresp;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    // Free-running jitter source, polynomial x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= 8'hA5;
        else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_wait = 5'(LAT) + {2'b00, r_lfsr[2:0]};
`else
    assign w_wait = 5'(LAT);
`endif

    assign w_rd_load = r_state != RD_RESP && w_next == RD_RESP;
    assign w_wr_load = r_state != WR_RESP && w_next == WR_RESP;

    // Next-state: read wins in IDLE, writes collect AW and W in any order, waits skip when zero
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (sram.arvalid)                    w_next = w_wait == '0 ? RD_RESP : RD_WAIT;
                else if (sram.awvalid & sram.wvalid) w_next = w_wait == '0 ? WR_RESP : WR_WAIT;
                else if (sram.awvalid | sram.wvalid) w_next = WR_COLLECT;
            end
            RD_WAIT:    if (r_cnt == '0) w_next = RD_RESP;
            RD_RESP:    if (sram.rready) w_next = IDLE;
            WR_COLLECT: if ((r_aw_got | sram.awvalid) & (r_w_got | sram.wvalid))
                            w_next = w_wait == '0 ? WR_RESP : WR_WAIT;
            WR_WAIT:    if (r_cnt == '0) w_next = WR_RESP;
            WR_RESP:    if (sram.bready) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // State, request capture, wait countdown and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            r_bresp  <= 2'b00;
        end else begin
            r_state  <= w_next;
            r_addr   <= w_addr;
            r_wdata  <= w_data;
            r_wstrb  <= w_strb;
            r_aw_got <= w_coll & r_aw_got | w_aw_take;
            r_w_got  <= w_coll & r_w_got | w_w_take;
            if (w_next == RD_WAIT || w_next == WR_WAIT)
                r_cnt <= w_next == r_state ? r_cnt - 5'd1 : w_wait - 5'd1;
            if (w_rd_load) begin
                r_rdata <= w_hit ? r_mem[w_idx] : '0;
                r_rresp <= w_hit ? 2'b00 : 2'b11;
            end
            if (w_wr_load)
                r_bresp <= w_hit ? 2'b00 : 2'b11;
        end
    end

    // Byte-masked store on entry to WR_RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n & w_wr_load & w_hit)
            for (int b = 0; b < 4; b++)
                if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
endmodule

// File: tb/tb_ysyx_23060240_sram_slave.sv
// tb_ysyx_23060240_sram_slave: directed checks of the SRAM slave with LAT=1, DEPTH_WORDS=4096
module tb_ysyx_23060240_sram_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060240_sram_slave_if bus ();

    ysyx_23060240_sram_slave #(
        .BASE_ADDR  (32'h8000_0000),
        .DEPTH_WORDS(4096),
        .LAT        (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sram (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_issue(input logic [31:0] a);
        int n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 60) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] r, output int lat);
        lat = 1;
        while (!bus.rvalid && lat < 60) begin @(negedge clk); lat++; end
        d = bus.rdata;
        r = bus.rresp;
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        rd_issue(a);
        wait_r(d, r, lat);
    endtask

    task automatic wait_b(output logic [1:0] r, output int lat);
        lat = 1;
        while (!bus.bvalid && lat < 60) begin @(negedge clk); lat++; end
        r = bus.bresp;
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r, output int lat);
        int n = 0;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        while (!(bus.awready && bus.wready) && n < 60) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_b(r, lat);
    endtask

    initial begin
        logic [31:0] d, d0;
        logic [1:0]  r;
        int          lat;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
        repeat (3) @(negedge clk);
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_arready", bus.arready, 1);
        check("post_rst_awready", bus.awready, 1);
        check("post_rst_wready", bus.wready, 1);
        check("post_rst_rvalid", bus.rvalid, 0);
        check("post_rst_bvalid", bus.bvalid, 0);
        check("post_rst_rdata", bus.rdata, 0);
        @(negedge clk);

        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
        check("t1_bresp", r, 0);
        check("t1_blat", lat, 2);
        rd(32'h8000_0010, d, r, lat);
        check("t1_rdata", d, 32'hDEAD_BEEF);
        check("t1_rresp", r, 0);
        check("t1_rlat", lat, 2);
        rd(32'h8000_0013, d, r, lat);
        check("low_bits_ignored", d, 32'hDEAD_BEEF);

        wr(32'h8000_0020, 32'h1122_3344, 4'hF, r, lat);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r, lat);
        check("t2_bresp", r, 0);
        rd(32'h8000_0020, d, r, lat);
        check("t2_strobe", d, 32'h11BB_33DD);
        wr(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, r, lat);
        check("t2_nostrb_bresp", r, 0);
        rd(32'h8000_0020, d, r, lat);
        check("t2_nostrb_data", d, 32'h11BB_33DD);

        bus.wdata  = 32'hCAFE_F00D;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("t3_wready_drop", bus.wready, 0);
        check("t3_awready_hold", bus.awready, 1);
        @(negedge clk);
        @(negedge clk);
        check("t3_no_early_b", bus.bvalid, 0);
        bus.awaddr  = 32'h8000_0030;
        bus.awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        wait_b(r, lat);
        check("t3_bresp", r, 0);
        check("t3_blat", lat, 2);
        check("t3_single_b_a", bus.bvalid, 0);
        @(negedge clk);
        check("t3_single_b_b", bus.bvalid, 0);
        rd(32'h8000_0030, d, r, lat);
        check("t3_data", d, 32'hCAFE_F00D);

        rd_issue(32'h8000_0010);
        lat = 0;
        while (!bus.rvalid && lat < 60) begin @(negedge clk); lat++; end
        d0 = bus.rdata;
        for (int i = 0; i < 5; i++) begin
            check("t4_rvalid", bus.rvalid, 1);
            check("t4_rdata", bus.rdata, 32'hDEAD_BEEF);
            check("t4_rresp", bus.rresp, 0);
            check("t4_arready", bus.arready, 0);
            @(negedge clk);
        end
        check("t4_first_data", d0, 32'hDEAD_BEEF);
        wait_r(d, r, lat);
        check("t4_final_data", d, 32'hDEAD_BEEF);
        check("t4_arready_after", bus.arready, 1);

        wr(32'h8000_0000, 32'h1234_5678, 4'hF, r, lat);
        rd(32'h7FFF_FFFC, d, r, lat);
        check("t5_low_rresp", r, 2'b11);
        check("t5_low_rdata", d, 0);
        wr(32'h8000_4000, 32'hBAD0_BAD0, 4'hF, r, lat);
        check("t5_high_bresp", r, 2'b11);
        rd(32'h8000_0000, d, r, lat);
        check("t5_mem_unchanged", d, 32'h1234_5678);
        rd(32'h8000_4000, d, r, lat);
        check("t5_high_rresp", r, 2'b11);
        wr(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, r, lat);
        check("t5_top_bresp", r, 0);
        rd(32'h8000_3FFC, d, r, lat);
        check("t5_top_data", d, 32'h0BAD_CAFE);

        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        bus.awaddr  = 32'h8000_0020;
        bus.wdata   = 32'h5555_5555;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("prio_awready", bus.awready, 0);
        check("prio_wready", bus.wready, 0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        wait_r(d, r, lat);
        check("prio_rdata", d, 32'hDEAD_BEEF);
        check("prio_bvalid", bus.bvalid, 0);
        rd(32'h8000_0020, d, r, lat);
        check("prio_no_write", d, 32'h11BB_33DD);

        rd_issue(32'h8000_0010);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", bus.rvalid, 0);
        check("t6_rst_arready", bus.arready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_arready", bus.arready, 1);
        check("t6_rvalid", bus.rvalid, 0);
        @(negedge clk);
        rd(32'h8000_0010, d, r, lat);
        check("t6_rdata", d, 32'hDEAD_BEEF);
        check("t6_rlat", lat, 2);

`ifdef SRAM_RAND_DELAY_EN
        for (int i = 0; i < 100; i++) begin
            rd(32'h8000_0010, d, r, lat);
            check("rand_lat_range", lat >= 2 && lat <= 9, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
